// File: rtl/sb_tx_msg_arbiter_if.sv
// Sideband TX message arbiter bus: requester side (level requests, packed
// messages, grant/ack) and sideband side (valid/message out, busy in).
// slave  = arbiter view, master = view of whoever drives requests/sideband.
interface sb_tx_msg_arbiter_if #(
  parameter int SB_MSG_WIDTH = 4,
  parameter int NUM_REQ      = 2
);
  logic                            i_enable;
  logic [NUM_REQ-1:0]              i_req_valid;
  logic [NUM_REQ*SB_MSG_WIDTH-1:0] i_req_msg;
  logic                            i_SB_Busy;
  logic                            i_falling_edge_busy;
  logic                            o_tx_msg_valid;
  logic [SB_MSG_WIDTH-1:0]         o_encoded_SB_msg;
  logic [NUM_REQ-1:0]              o_grant;
  logic [NUM_REQ-1:0]              o_req_ack;
  logic                            o_arb_busy;

  modport slave (
    input  i_enable, i_req_valid, i_req_msg, i_SB_Busy, i_falling_edge_busy,
    output o_tx_msg_valid, o_encoded_SB_msg, o_grant, o_req_ack, o_arb_busy
  );

  modport master (
    output i_enable, i_req_valid, i_req_msg, i_SB_Busy, i_falling_edge_busy,
    input  o_tx_msg_valid, o_encoded_SB_msg, o_grant, o_req_ack, o_arb_busy
  );
endinterface

// File: rtl/sb_tx_msg_arbiter.sv
// Sideband TX message arbiter: picks one of NUM_REQ requesters, presents its
// message to the sideband until busy is seen, then acks it on the busy
// falling edge, followed by a one-cycle gap before the next arbitration.
// Optional: define SB_ARB_RR_EN for round-robin selection (pointer advances
// on ack only); otherwise fixed lowest-index priority.
module sb_tx_msg_arbiter #(
  parameter int SB_MSG_WIDTH = 4,
  parameter int NUM_REQ      = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  sb_tx_msg_arbiter_if.slave  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  logic [1:0]              state_q, state_d;
  logic                    valid_q, valid_d;
  logic [SB_MSG_WIDTH-1:0] msg_q, msg_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic                    arb_busy_q, arb_busy_d;

  logic                    sel_found;
  logic [IDX_W-1:0]        sel_idx;
  logic [NUM_REQ-1:0]      sel_onehot;

  logic [SB_MSG_WIDTH-1:0] req_msg_arr [NUM_REQ];

  // Unpack the flat message bus into one entry per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_msg_arr[gi] = bus.i_req_msg[gi*SB_MSG_WIDTH +: SB_MSG_WIDTH];
  end

`ifdef SB_ARB_RR_EN
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  // Round-robin search starting at the pointer, wrapping at NUM_REQ.
  always_comb begin
    int cand;
    cand      = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(rr_ptr_q) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!sel_found && bus.i_req_valid[cand[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
  end
`else
  // Fixed priority: lowest requesting index wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.i_req_valid[k]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(k);
      end
    end
  end
`endif

  // One-hot form of the selected index for the grant output.
  always_comb begin
    sel_onehot          = '0;
    sel_onehot[sel_idx] = 1'b1;
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    msg_d   = msg_q;
    grant_d = grant_q;
    ack_d   = '0;
`ifdef SB_ARB_RR_EN
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.i_enable && sel_found && !bus.i_SB_Busy) begin
          state_d = ST_ISSUE;
          valid_d = 1'b1;
          msg_d   = req_msg_arr[sel_idx];
          grant_d = sel_onehot;
`ifdef SB_ARB_RR_EN
          idx_d   = sel_idx;
`endif
        end
      end
      ST_ISSUE: begin
        // Busy wins over a disable: once the SB has taken it, it must finish.
        if (bus.i_SB_Busy) begin
          state_d = ST_WAIT;
          valid_d = 1'b0;
          msg_d   = '0;
        end else if (!bus.i_enable) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          msg_d   = '0;
          grant_d = '0;
        end
      end
      ST_WAIT: begin
        if (bus.i_falling_edge_busy) begin
          state_d = ST_GAP;
          ack_d   = grant_q;
          grant_d = '0;
`ifdef SB_ARB_RR_EN
          rr_ptr_d = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
`endif
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        msg_d   = '0;
        grant_d = '0;
      end
    endcase
    arb_busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      valid_q    <= 1'b0;
      msg_q      <= '0;
      grant_q    <= '0;
      ack_q      <= '0;
      arb_busy_q <= 1'b0;
`ifdef SB_ARB_RR_EN
      idx_q      <= '0;
      rr_ptr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      msg_q      <= msg_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      arb_busy_q <= arb_busy_d;
`ifdef SB_ARB_RR_EN
      idx_q      <= idx_d;
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  assign bus.o_tx_msg_valid   = valid_q;
  assign bus.o_encoded_SB_msg = msg_q;
  assign bus.o_grant          = grant_q;
  assign bus.o_req_ack        = ack_q;
  assign bus.o_arb_busy       = arb_busy_q;

endmodule
